md_ctrl: RTL and testbench

MD_CTRL -- requirements
Module: md_ctrl

---
 rtl/md_ctrl.sv | 153 +++++++++++++++
 tb/tb_md_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/md_ctrl.sv
// Multiply/divide controller with architectural HI/LO registers and pipeline stall generation.
// Define MD_DIV_EN to include div/divu support; without it only mult/multu are accepted.
module md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    input  logic        md_use_d,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        md_stall
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
`ifdef MD_DIV_EN
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [4:0] DIV_LOAD = 5'(DIV_CYCLES);
`endif
    localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES);

    logic [1:0]  state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic        unsigned_q, unsigned_d;
    logic [31:0] rs_q, rs_d;
    logic [31:0] rt_q, rt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Sign-extending to 64 bits lets one multiplier serve both mult and multu.
    logic        rs_ext, rt_ext;
    logic [63:0] product;

    always_comb begin
        rs_ext  = ~unsigned_q & rs_q[31];
        rt_ext  = ~unsigned_q & rt_q[31];
        product = {{32{rs_ext}}, rs_q} * {{32{rt_ext}}, rt_q};
    end

`ifdef MD_DIV_EN
    logic        rs_neg, rt_neg, div_by_zero;
    logic [31:0] rs_mag, rt_mag, den, q_mag, r_mag, quotient, remainder;

    // Divide on magnitudes, then restore signs: quotient truncates toward zero,
    // remainder follows the dividend.
    always_comb begin
        rs_neg      = ~unsigned_q & rs_q[31];
        rt_neg      = ~unsigned_q & rt_q[31];
        rs_mag      = rs_neg ? (32'd0 - rs_q) : rs_q;
        rt_mag      = rt_neg ? (32'd0 - rt_q) : rt_q;
        div_by_zero = (rt_q == 32'd0);
        den         = div_by_zero ? 32'd1 : rt_mag;
        q_mag       = rs_mag / den;
        r_mag       = rs_mag % den;
        quotient    = (rs_neg ^ rt_neg) ? (32'd0 - q_mag) : q_mag;
        remainder   = rs_neg ? (32'd0 - r_mag) : r_mag;
    end
`endif

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        unsigned_d = unsigned_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (!op[1]) begin
                        state_d    = S_MUL;
                        count_d    = MULT_LOAD;
                        unsigned_d = op[0];
                        rs_d       = rs_val;
                        rt_d       = rt_val;
                    end
`ifdef MD_DIV_EN
                    else begin
                        state_d    = S_DIV;
                        count_d    = DIV_LOAD;
                        unsigned_d = op[0];
                        rs_d       = rs_val;
                        rt_d       = rt_val;
                    end
`endif
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            S_MUL: begin
                count_d = count_q - 5'd1;
                if (count_q == 5'd1) begin
                    state_d = S_IDLE;
                    hi_d    = product[63:32];
                    lo_d    = product[31:0];
                end
            end
`ifdef MD_DIV_EN
            S_DIV: begin
                count_d = count_q - 5'd1;
                if (count_q == 5'd1) begin
                    state_d = S_IDLE;
                    if (!div_by_zero) begin
                        hi_d = remainder;
                        lo_d = quotient;
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                count_d = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            count_q    <= 5'd0;
            unsigned_q <= 1'b0;
            rs_q       <= 32'd0;
            rt_q       <= 32'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            unsigned_q <= unsigned_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign md_stall = md_use_d & (start | busy);

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: directed scenarios followed by random traffic,
// all compared against a cycle-level arithmetic reference model.
module tb_md_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
`ifdef MD_DIV_EN
    localparam bit divEn = 1'b1;
`else
    localparam bit divEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        hi_we, lo_we;
    logic [31:0] wdata;
    logic        md_use_d;
    logic        busy;
    logic [31:0] hi, lo;
    logic        md_stall;

    int errorCount = 0;
    int checkCount = 0;

    // Reference model state: remaining busy cycles and the result waiting to land.
    int          mBusyLeft;
    logic [31:0] mHi, mLo;
    logic [63:0] mPending;
    bit          mPendValid;

    md_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .hi_we(hi_we), .lo_we(lo_we),
        .wdata(wdata), .md_use_d(md_use_d), .busy(busy), .hi(hi), .lo(lo),
        .md_stall(md_stall)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Architectural result as {hi,lo}, from plain integer arithmetic.
    function automatic logic [63:0] mdResult(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            2'b00: res = 64'(sa * sb);
            2'b01: res = ua * ub;
            2'b10: begin
                q   = sa / sb;
                r   = sa % sb;
                res = {r[31:0], q[31:0]};
            end
            default: res = {a % b, a / b};
        endcase
        return res;
    endfunction

    task automatic modelReset();
        mBusyLeft  = 0;
        mHi        = 32'd0;
        mLo        = 32'd0;
        mPendValid = 1'b0;
        mPending   = 64'd0;
    endtask

    task automatic modelStep();
        if (mBusyLeft > 0) begin
            mBusyLeft--;
            if (mBusyLeft == 0 && mPendValid) begin
                mHi = mPending[63:32];
                mLo = mPending[31:0];
            end
        end else if (start) begin
            if (!op[1] || divEn) begin
                mBusyLeft  = op[1] ? DIV_N : MULT_N;
                mPendValid = !(op[1] && rt_val == 32'd0);
                if (mPendValid) mPending = mdResult(op, rs_val, rt_val);
            end
        end else begin
            if (hi_we) mHi = wdata;
            if (lo_we) mLo = wdata;
        end
    endtask

    // One clock cycle: drive on the falling edge, check stall before the rising
    // edge, advance the model, then check registered outputs just after the edge.
    task automatic applyStimulus(input logic s, input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic hw, input logic lw,
                                 input logic [31:0] wd, input logic use_d);
        @(negedge clk);
        start = s; op = o; rs_val = a; rt_val = b;
        hi_we = hw; lo_we = lw; wdata = wd; md_use_d = use_d;
        #1;
        checkOutput("md_stall", {31'd0, md_stall}, {31'd0, use_d && (s || mBusyLeft > 0)});
        @(posedge clk);
        modelStep();
        #1;
        checkOutput("busy", {31'd0, busy}, {31'd0, mBusyLeft > 0});
        checkOutput("hi", hi, mHi);
        checkOutput("lo", lo, mLo);
    endtask

    task automatic idleCycles(input int n, input logic use_d);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 2'b00, $urandom, $urandom, 1'b0, 1'b0, $urandom, use_d);
    endtask

    initial begin
        logic [31:0] a, b;
        logic [1:0]  o;

        reset_n = 1'b0; start = 1'b0; op = 2'b00; rs_val = 32'd0; rt_val = 32'd0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0; md_use_d = 1'b0;
        modelReset();
        #2;
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);
        checkOutput("reset_stall", {31'd0, md_stall}, 32'd0);
        start = 1'b1; md_use_d = 1'b1;
        #1;
        checkOutput("reset_stall_start", {31'd0, md_stall}, 32'd1);
        start = 1'b0; md_use_d = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] signed multiply with stall window");
        applyStimulus(1'b1, 2'b00, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0, 32'd0, 1'b1);
        idleCycles(MULT_N - 1, 1'b1);
        idleCycles(1, 1'b1);
        checkOutput("mult_hi", hi, 32'hFFFFFFFF);
        checkOutput("mult_lo", lo, 32'hFFFFFFFA);

        $display("[TB] unsigned multiply");
        applyStimulus(1'b1, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'd0, 1'b0);
        idleCycles(MULT_N, 1'b0);
        checkOutput("multu_hi", hi, 32'hFFFFFFFE);
        checkOutput("multu_lo", lo, 32'h00000001);

        $display("[TB] signed divide, divide by zero, overflow case");
        applyStimulus(1'b1, 2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 32'd0, 1'b0);
        idleCycles(DIV_N, 1'b0);
        checkOutput("div_lo", lo, divEn ? 32'hFFFFFFFD : 32'h00000001);
        checkOutput("div_hi", hi, divEn ? 32'hFFFFFFFF : 32'hFFFFFFFE);
        applyStimulus(1'b1, 2'b10, 32'hFFFFFFF9, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        idleCycles(DIV_N, 1'b0);
        checkOutput("div0_lo", lo, divEn ? 32'hFFFFFFFD : 32'h00000001);
        checkOutput("div0_hi", hi, divEn ? 32'hFFFFFFFF : 32'hFFFFFFFE);
        applyStimulus(1'b1, 2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'd0, 1'b0);
        idleCycles(DIV_N, 1'b0);
        checkOutput("divovf_lo", lo, divEn ? 32'h80000000 : 32'h00000001);
        checkOutput("divovf_hi", hi, divEn ? 32'h00000000 : 32'hFFFFFFFE);

        $display("[TB] start and mthi ignored while busy");
        applyStimulus(1'b1, 2'b01, 32'd7, 32'd6, 1'b0, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b1, 2'b00, 32'd100, 32'd100, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1);
        idleCycles(MULT_N - 1, 1'b0);
        checkOutput("ignored_lo", lo, 32'd42);

        $display("[TB] reset in the middle of a divide");
        applyStimulus(1'b1, 2'b11, 32'd1000, 32'd7, 1'b0, 1'b0, 32'd0, 1'b0);
        idleCycles(2, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        modelReset();
        checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
        checkOutput("midreset_hi", hi, 32'd0);
        checkOutput("midreset_lo", lo, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        idleCycles(DIV_N + 2, 1'b0);
        applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b0, 32'h12345678, 1'b0);
        checkOutput("mthi_hi", hi, 32'h12345678);
        checkOutput("mthi_lo", lo, 32'd0);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            o = 2'($urandom);
            a = ($urandom % 8 == 0) ? 32'h80000000 : $urandom;
            case ($urandom % 8)
                0:       b = 32'd0;
                1:       b = 32'hFFFFFFFF;
                2:       b = $urandom % 16;
                default: b = $urandom;
            endcase
            applyStimulus($urandom % 4 == 0, o, a, b, $urandom % 5 == 0, $urandom % 5 == 0,
                          $urandom, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
